// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: register number, shadow entry and
// the per-stage stall rule used by the producer-side scoreboard.
package cpuDefine;

   localparam int GR_W    = 5;
   localparam int STG_EX  = 0;
   localparam int STG_MEM = 1;
   localparam int STG_WB  = 2;
   localparam int N_STG   = 3;

   typedef logic [GR_W-1:0] Gr;

   typedef struct packed {
      logic valid;
      logic wen;
      Gr    rd_no;
      logic is_load;
   } sb_entry_t;

   // Whether a live writer in a given stage is too young for the bypass network:
   // in_id marks a source consumed in ID rather than in EX.
   function automatic logic stall_needed(input int stage, input logic in_id,
                                         input logic is_load);
      case (stage)
         STG_EX:  return in_id | is_load;
         STG_MEM: return in_id & is_load;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// Compares one source register number against one shadow entry.
module sb_match
   import cpuDefine::*;
(
   input  Gr         src_no,
   input  sb_entry_t entry,
   output logic      live_match,
   output logic      is_load
);

   // Register 0 is hardwired, so a write to it never creates a dependency.
   assign live_match = entry.valid & entry.wen & (entry.rd_no != '0) &
                       (entry.rd_no == src_no);
   assign is_load    = entry.is_load;

endmodule

// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard: shadows the EX/MEM/WB writers and stalls ID
// whenever an operand cannot be bypassed in time, injecting an EX bubble.
module hazard_scoreboard
   import cpuDefine::*;
#(
   parameter int GR_W  = 5,
   parameter int CNT_W = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   input  logic             issue_wen,
   input  logic [GR_W-1:0]  issue_rd_no,
   input  logic             issue_is_load,
   input  logic [GR_W-1:0]  rj_no_id,
   input  logic [GR_W-1:0]  rk_no_id,
   input  logic [GR_W-1:0]  rd_no_id,
   input  logic             rj_use_id,
   input  logic             rd_use_id,
   input  logic             rj_use_ex,
   input  logic             rk_use_ex,
   input  logic             rd_use_ex,
   input  logic             pipe_freeze,
   input  logic             flush,
   output logic             stall_id,
   output logic [CNT_W-1:0] perf_stall_cnt
);

   localparam int N_SRC = 5;
   // Sources 0..1 are consumed in ID, 2..4 in EX.
   localparam logic [N_SRC-1:0] SRC_IN_ID = 5'b00011;

   sb_entry_t              stage_reg [N_STG];
   sb_entry_t              issue_entry;
   Gr                      src_no [N_SRC];
   logic [N_SRC-1:0]       src_use;
   logic [N_STG*N_SRC-1:0] hazard;

   assign src_no[0] = Gr'(rj_no_id);
   assign src_no[1] = Gr'(rd_no_id);
   assign src_no[2] = Gr'(rj_no_id);
   assign src_no[3] = Gr'(rk_no_id);
   assign src_no[4] = Gr'(rd_no_id);
   assign src_use   = {rd_use_ex, rk_use_ex, rj_use_ex, rd_use_id, rj_use_id};

   assign issue_entry = '{valid:   issue_valid,
                          wen:     issue_wen,
                          rd_no:   Gr'(issue_rd_no),
                          is_load: issue_is_load};

   for (genvar gi = 0; gi < N_STG; gi++) begin : g_stage
      for (genvar gj = 0; gj < N_SRC; gj++) begin : g_src
         logic live_match;
         logic is_load;

         sb_match u_match (
            .src_no     (src_no[gj]),
            .entry      (stage_reg[gi]),
            .live_match (live_match),
            .is_load    (is_load)
         );

         assign hazard[gi*N_SRC+gj] = live_match & src_use[gj] &
                                      stall_needed(gi, SRC_IN_ID[gj], is_load);
      end
   end

   // Freeze deliberately does not mask the stall: ID must keep holding.
   assign stall_id = issue_valid & ~flush & (|hazard);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_STG; i++) begin
            stage_reg[i] <= '0;
         end
         perf_stall_cnt <= '0;
      end else begin
         if (flush) begin
            stage_reg[STG_EX].valid <= 1'b0;
            if (!pipe_freeze) begin
               stage_reg[STG_MEM] <= stage_reg[STG_EX];
               stage_reg[STG_WB]  <= stage_reg[STG_MEM];
            end
         end else if (!pipe_freeze) begin
            stage_reg[STG_EX]  <= stall_id ? '0 : issue_entry;
            stage_reg[STG_MEM] <= stage_reg[STG_EX];
            stage_reg[STG_WB]  <= stage_reg[STG_MEM];
         end

         if (stall_id && !pipe_freeze && !(&perf_stall_cnt)) begin
            perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each task drives one scenario and
// checks stall_id, the stall counter and the EX shadow entry inline.
module tb_hazard_scoreboard;

   localparam int GR_W  = 5;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             issue_valid;
   logic             issue_wen;
   logic [GR_W-1:0]  issue_rd_no;
   logic             issue_is_load;
   logic [GR_W-1:0]  rj_no_id;
   logic [GR_W-1:0]  rk_no_id;
   logic [GR_W-1:0]  rd_no_id;
   logic             rj_use_id;
   logic             rd_use_id;
   logic             rj_use_ex;
   logic             rk_use_ex;
   logic             rd_use_ex;
   logic             pipe_freeze;
   logic             flush;
   logic             stall_id;
   logic [CNT_W-1:0] perf_stall_cnt;

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   hazard_scoreboard #(.GR_W(GR_W), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .issue_valid    (issue_valid),
      .issue_wen      (issue_wen),
      .issue_rd_no    (issue_rd_no),
      .issue_is_load  (issue_is_load),
      .rj_no_id       (rj_no_id),
      .rk_no_id       (rk_no_id),
      .rd_no_id       (rd_no_id),
      .rj_use_id      (rj_use_id),
      .rd_use_id      (rd_use_id),
      .rj_use_ex      (rj_use_ex),
      .rk_use_ex      (rk_use_ex),
      .rd_use_ex      (rd_use_ex),
      .pipe_freeze    (pipe_freeze),
      .flush          (flush),
      .stall_id       (stall_id),
      .perf_stall_cnt (perf_stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      issue_valid = 0; issue_wen = 0; issue_rd_no = 0; issue_is_load = 0;
      rj_no_id = 0; rk_no_id = 0; rd_no_id = 0;
      rj_use_id = 0; rd_use_id = 0; rj_use_ex = 0; rk_use_ex = 0; rd_use_ex = 0;
      pipe_freeze = 0; flush = 0;
   endtask

   // Advance one edge; inputs are then changed 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_writer(input logic [GR_W-1:0] rd, input logic ld);
      clear_inputs();
      issue_valid = 1; issue_wen = 1; issue_rd_no = rd; issue_is_load = ld;
   endtask

   task automatic drain();
      clear_inputs();
      repeat (4) tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      #1;
      total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_id); end
      total++; if (perf_stall_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", perf_stall_cnt); end
      tick(); tick();
      rst = 0;
      issue_valid = 1; rj_no_id = 5; rj_use_id = 1; rk_no_id = 5; rk_use_ex = 1;
      #1;
      total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL reset_empty_stall got=%b want=0", stall_id); end
      $display("test_reset done");
      drain();
   endtask

   task automatic test_alu_id_use();
      issue_writer(4, 0);
      tick();
      clear_inputs();
      issue_valid = 1; rj_no_id = 4; rj_use_id = 1; rd_no_id = 9; rd_use_id = 1;
      #1;
      total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL alu_id_c0 got=%b want=1", stall_id); end
      exp_cnt++;
      tick();
      total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL alu_id_c1 got=%b want=0", stall_id); end
      total++; if (perf_stall_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL alu_id_cnt got=%0d want=%0d", perf_stall_cnt, exp_cnt); end
      $display("test_alu_id_use done");
      drain();
   endtask

   task automatic test_load_use();
      issue_writer(5, 1);
      tick();
      clear_inputs();
      issue_valid = 1; issue_wen = 1; issue_rd_no = 6;
      rj_no_id = 5; rk_no_id = 7; rj_use_ex = 1; rk_use_ex = 1;
      #1;
      total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL ldu_c0 got=%b want=1", stall_id); end
      exp_cnt++;
      tick();
      total++; if (dut.stage_reg[0].valid !== 1'b0) begin bad++; $display("FAIL ldu_bubble got=%b want=0", dut.stage_reg[0].valid); end
      total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL ldu_c1 got=%b want=0", stall_id); end
      tick();
      total++; if (dut.stage_reg[0].valid !== 1'b1) begin bad++; $display("FAIL ldu_issued got=%b want=1", dut.stage_reg[0].valid); end
      total++; if (perf_stall_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL ldu_cnt got=%0d want=%0d", perf_stall_cnt, exp_cnt); end
      $display("test_load_use done");
      drain();
   endtask

   task automatic test_load_id_use();
      issue_writer(5, 1);
      tick();
      clear_inputs();
      issue_valid = 1; rj_no_id = 5; rj_use_id = 1; rd_no_id = 9; rd_use_id = 1;
      #1;
      total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL ldid_c0 got=%b want=1", stall_id); end
      tick();
      total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL ldid_c1 got=%b want=1", stall_id); end
      tick();
      total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL ldid_c2 got=%b want=0", stall_id); end
      exp_cnt += 2;
      total++; if (perf_stall_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL ldid_cnt got=%0d want=%0d", perf_stall_cnt, exp_cnt); end
      $display("test_load_id_use done");
      drain();
   endtask

   task automatic test_r0();
      issue_writer(0, 1);
      tick();
      clear_inputs();
      issue_valid = 1;
      rj_use_id = 1; rd_use_id = 1; rj_use_ex = 1; rk_use_ex = 1; rd_use_ex = 1;
      #1;
      total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL r0_ex got=%b want=0", stall_id); end
      tick();
      total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL r0_mem got=%b want=0", stall_id); end
      $display("test_r0 done");
      drain();
   endtask

   task automatic test_freeze();
      issue_writer(5, 1);
      tick();
      clear_inputs();
      issue_valid = 1; rj_no_id = 5; rj_use_ex = 1; pipe_freeze = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL frz_stall[%0d] got=%b want=1", c, stall_id); end
         tick();
         total++; if (dut.stage_reg[0].valid !== 1'b1 || dut.stage_reg[0].rd_no !== 5'd5) begin
            bad++; $display("FAIL frz_hold[%0d] got=%b/%0d want=1/5", c, dut.stage_reg[0].valid, dut.stage_reg[0].rd_no);
         end
         total++; if (perf_stall_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL frz_cnt[%0d] got=%0d want=%0d", c, perf_stall_cnt, exp_cnt); end
      end
      pipe_freeze = 0;
      #1;
      total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL frz_release got=%b want=1", stall_id); end
      exp_cnt++;
      tick();
      total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL frz_clear got=%b want=0", stall_id); end
      total++; if (perf_stall_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL frz_cnt_after got=%0d want=%0d", perf_stall_cnt, exp_cnt); end
      $display("test_freeze done");
      drain();
   endtask

   task automatic test_flush_and_reset();
      issue_writer(5, 1);
      tick();
      clear_inputs();
      issue_valid = 1; rj_no_id = 5; rj_use_ex = 1; flush = 1;
      #1;
      total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", stall_id); end
      tick();
      total++; if (dut.stage_reg[0].valid !== 1'b0) begin bad++; $display("FAIL flush_ex got=%b want=0", dut.stage_reg[0].valid); end
      total++; if (perf_stall_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL flush_cnt got=%0d want=%0d", perf_stall_cnt, exp_cnt); end
      drain();

      issue_writer(5, 1);
      tick();
      clear_inputs();
      issue_valid = 1; rj_no_id = 5; rj_use_id = 1;
      #1;
      total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b want=1", stall_id); end
      rst = 1;
      #1;
      exp_cnt = 0;
      total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b want=0", stall_id); end
      total++; if (perf_stall_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL rstmid_cnt got=%0d want=0", perf_stall_cnt); end
      tick();
      rst = 0;
      #1;
      total++; if (dut.stage_reg[0].valid !== 1'b0 || dut.stage_reg[1].valid !== 1'b0 || dut.stage_reg[2].valid !== 1'b0) begin
         bad++; $display("FAIL rstmid_entries got=%b%b%b want=000", dut.stage_reg[0].valid, dut.stage_reg[1].valid, dut.stage_reg[2].valid);
      end
      total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL rstmid_after got=%b want=0", stall_id); end
      $display("test_flush_and_reset done");
      drain();
   endtask

   initial begin
      test_reset();
      test_alu_id_use();
      test_load_use();
      test_load_id_use();
      test_r0();
      test_freeze();
      test_flush_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
